niu_sii_dma_req_tx: RTL and testbench
=====================================

Name: niu_sii_dma_req_tx

Overview:
NIU-side transmitter for the NIU-to-SII inbound DMA request interface. It accepts DMA read and write requests from the NIU DMA engine over a valid/ready handshake. It issues each request as a one-cycle header on niu_sii_data, and for writes follows the header with exactly 4 payload beats. It tracks SII ordered-queue and bypass-queue credits, so no request is issued without a free destination entry.

Parameters:
OQ_CREDITS, 16, ordered-queue entries available after reset
BQ_CREDITS, 16, bypass-queue entries available after reset
CW, 5, credit counter width; must hold max(OQ_CREDITS,BQ_CREDITS)

Ports:
iol2clk  in  1  clock
reset  in  1  synchronous active-high reset
req_vld  in  1  DMA engine request valid
req_rdy  out  1  request accepted when req_vld&&req_rdy
req_wr  in  1  1=write (64B payload), 0=read
req_bypass  in  1  1=bypass queue, 0=ordered queue
req_tag  in  16  NIU tag ID
req_pa  in  40  physical address
req_be  in  16  byte enables, driven with header
req_data  in  512  write payload, beat k = req_data[128k+127:128k]
sii_niu_oqdq  in  1  one-cycle pulse: SII dequeued an ordered-queue entry
sii_niu_bqdq  in  1  one-cycle pulse: SII dequeued a bypass-queue entry
niu_sii_hdr_vld  out  1  header cycle
niu_sii_reqbypass  out  1  header destination queue
niu_sii_datareq  out  1  header of a write request
niu_sii_datareq16  out  1  16B write; tied 0
niu_sii_data  out  128  header or payload beat
niu_sii_parity  out  8  parity per 16-bit lane
niu_sii_be  out  16  byte enables
credit_err  out  1  sticky: credit return while counter already at its maximum

Behaviour:
- Reset: all outputs 0 (req_rdy=0 during reset). Credit counters load OQ_CREDITS/BQ_CREDITS. FSM goes to IDLE, dropping any header or payload in flight. credit_err clears.
- FSM states: IDLE, HDR, PAY. beat counter is 2 bits.
  - Accept in any state → HDR next cycle.
  - HDR with write → PAY, beat=0.
  - HDR with read and no accept → IDLE.
  - PAY beat 0..2 → PAY, beat+1.
  - PAY beat 3 → HDR if accept, else IDLE.
- Accept window: req_rdy = credit_ok && (IDLE || (HDR && latched request is read) || (PAY && beat==3)).
  - credit_ok = req_bypass ? bq_cnt!=0 : oq_cnt!=0.
  - req_rdy may depend combinationally on req_bypass.
- Latency: a request accepted at cycle N drives its header at N+1, with all outputs registered. Write payload beats follow at N+2..N+5, beat 0 first.
- Back-to-back:
  - Reads can be accepted every cycle, giving a header every cycle.
  - A write blocks acceptance until its last beat. A request accepted on the last beat drives its header in the next cycle, with no bubble.
- Header cycle outputs: hdr_vld=1, datareq=req_wr, reqbypass=req_bypass, be=req_be.
  - data[79:64]=tag and data[39:0]=PA.
  - All other data bits are 0.
- Payload cycles: hdr_vld=0, datareq=0, reqbypass=0, be=0, data=beat.
- Idle: data=0, parity=0.
- Parity: every cycle, niu_sii_parity[i] = ^niu_sii_data[16i+15:16i] (even parity), computed on the registered data.
- Inputs are captured at acceptance. Later changes to req_* do not affect a request in flight.
- Credits:
  - Decrement the selected counter at acceptance.
  - Increment on the dq pulse.
  - Simultaneous decrement and increment on the same counter leaves it unchanged.
  - An increment while the counter is at its parameter maximum saturates and sets credit_err, which stays set until reset.
  - A dq pulse arriving in the cycle a counter is 0 makes credit available in the next cycle, not the same cycle.
- Counters never underflow, because req_rdy is gated by credit_ok.

Test Plan:
- Single read: reset, then req_vld with wr=0, bypass=1, tag=0x1234, pa=0x12_3456_7890 → one cycle later hdr_vld=1, datareq=0, reqbypass=1, data[79:64]=0x1234, data[39:0]=0x1234567890, parity matches; bq_cnt 16→15.
- Single write: data beats 0xA..A, 0xB..B, 0xC..C, 0xD..D, be=0xFFFF → header with datareq=1, then 4 consecutive beats in order; hdr_vld=0 during beats; req_rdy=0 until beat 3.
- Back-to-back: 3 reads followed by 1 write, req_vld held high → headers on 3 consecutive cycles, write header on the next cycle, payload after it; a second write accepted on beat 3 gives its header with no gap.
- Credit exhaustion: OQ_CREDITS=2 with 3 ordered reads → 2 issued, then req_rdy=0; an oqdq pulse enables the third issue one cycle later; a simultaneous accept and oqdq keeps the count constant.
- Overflow: an oqdq pulse at oq_cnt=16 → counter stays 16, credit_err=1 and remains set.
- Reset mid-write: assert reset during beat 1 → next cycle all outputs 0, FSM in IDLE, counters reloaded to 16/16, no further beats driven.

Source files
------------

// File: rtl/niu_sii_dma_req_tx.sv
// NIU-to-SII inbound DMA request transmitter: sequences headers and write payload
// beats, tracks SII ordered/bypass queue credits and generates per-lane parity.
module niu_sii_dma_req_tx #(
  parameter int OQ_CREDITS = 16,
  parameter int BQ_CREDITS = 16,
  parameter int CW         = 5
) (
  input  logic         iol2clk,
  input  logic         reset,
  input  logic         req_vld,
  output logic         req_rdy,
  input  logic         req_wr,
  input  logic         req_bypass,
  input  logic [15:0]  req_tag,
  input  logic [39:0]  req_pa,
  input  logic [15:0]  req_be,
  input  logic [511:0] req_data,
  input  logic         sii_niu_oqdq,
  input  logic         sii_niu_bqdq,
  output logic         niu_sii_hdr_vld,
  output logic         niu_sii_reqbypass,
  output logic         niu_sii_datareq,
  output logic         niu_sii_datareq16,
  output logic [127:0] niu_sii_data,
  output logic [7:0]   niu_sii_parity,
  output logic [15:0]  niu_sii_be,
  output logic         credit_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_t;

  localparam logic [CW-1:0] OQ_MAX  = CW'(OQ_CREDITS);
  localparam logic [CW-1:0] BQ_MAX  = CW'(BQ_CREDITS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  state_t         state_r, state_nxt_s;
  logic [1:0]     beat_r, beat_nxt_s;
  logic [CW-1:0]  oq_cnt_r, bq_cnt_r;
  logic           wr_r;
  logic [511:0]   data_r;
  logic           credit_ok_s, window_s, accept_s;
  logic           oq_dec_s, bq_dec_s, oq_ovf_s, bq_ovf_s;
  logic           hdr_vld_nxt_s, reqbypass_nxt_s, datareq_nxt_s;
  logic [15:0]    be_nxt_s;
  logic [127:0]   data_nxt_s;
  logic           hdr_vld_r, reqbypass_r, datareq_r, credit_err_r;
  logic [15:0]    be_r;
  logic [127:0]   data_r_out;
  logic [7:0]     parity_r;

  // Even parity over each 16-bit lane of a 128-bit beat
  function automatic logic [7:0] lane_parity(input logic [127:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) begin
      p[i] = ^d[16*i +: 16];
    end
    return p;
  endfunction

  // Acceptance window: credit for the requested queue and a free slot in the sequence
  always_comb begin
    credit_ok_s = req_bypass ? (bq_cnt_r != CNT_ZERO) : (oq_cnt_r != CNT_ZERO);
    case (state_r)
      ST_IDLE: window_s = 1'b1;
      ST_HDR:  window_s = ~wr_r;
      ST_PAY:  window_s = (beat_r == 2'd3);
      default: window_s = 1'b0;
    endcase
    req_rdy  = ~reset & credit_ok_s & window_s;
    accept_s = req_vld & req_rdy;
    oq_dec_s = accept_s & ~req_bypass;
    bq_dec_s = accept_s & req_bypass;
    oq_ovf_s = sii_niu_oqdq & ~oq_dec_s & (oq_cnt_r == OQ_MAX);
    bq_ovf_s = sii_niu_bqdq & ~bq_dec_s & (bq_cnt_r == BQ_MAX);
  end

  // Next state and next registered SII outputs; a new header always wins
  always_comb begin
    state_nxt_s     = ST_IDLE;
    beat_nxt_s      = 2'd0;
    hdr_vld_nxt_s   = 1'b0;
    reqbypass_nxt_s = 1'b0;
    datareq_nxt_s   = 1'b0;
    be_nxt_s        = 16'd0;
    data_nxt_s      = 128'd0;
    if (accept_s) begin
      state_nxt_s     = ST_HDR;
      hdr_vld_nxt_s   = 1'b1;
      reqbypass_nxt_s = req_bypass;
      datareq_nxt_s   = req_wr;
      be_nxt_s        = req_be;
      data_nxt_s      = {48'd0, req_tag, 24'd0, req_pa};
    end else begin
      case (state_r)
        ST_HDR: begin
          if (wr_r) begin
            state_nxt_s = ST_PAY;
            beat_nxt_s  = 2'd0;
            data_nxt_s  = data_r[127:0];
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_PAY: begin
          if (beat_r != 2'd3) begin
            state_nxt_s = ST_PAY;
            beat_nxt_s  = beat_r + 2'd1;
            data_nxt_s  = data_r[{beat_nxt_s, 7'd0} +: 128];
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Sequencer state, captured request and registered SII outputs
  always_ff @(posedge iol2clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      beat_r      <= 2'd0;
      wr_r        <= 1'b0;
      data_r      <= 512'd0;
      hdr_vld_r   <= 1'b0;
      reqbypass_r <= 1'b0;
      datareq_r   <= 1'b0;
      be_r        <= 16'd0;
      data_r_out  <= 128'd0;
      parity_r    <= 8'd0;
    end else begin
      state_r     <= state_nxt_s;
      beat_r      <= beat_nxt_s;
      hdr_vld_r   <= hdr_vld_nxt_s;
      reqbypass_r <= reqbypass_nxt_s;
      datareq_r   <= datareq_nxt_s;
      be_r        <= be_nxt_s;
      data_r_out  <= data_nxt_s;
      parity_r    <= lane_parity(data_nxt_s);
      if (accept_s) begin
        wr_r   <= req_wr;
        data_r <= req_data;
      end
    end
  end

  // Queue credits: take on accept, return on dequeue, saturate and flag on overflow
  always_ff @(posedge iol2clk) begin
    if (reset) begin
      oq_cnt_r     <= OQ_MAX;
      bq_cnt_r     <= BQ_MAX;
      credit_err_r <= 1'b0;
    end else begin
      credit_err_r <= credit_err_r | oq_ovf_s | bq_ovf_s;
      if (oq_dec_s && !sii_niu_oqdq) begin
        oq_cnt_r <= oq_cnt_r - CNT_ONE;
      end else if (!oq_dec_s && sii_niu_oqdq && !oq_ovf_s) begin
        oq_cnt_r <= oq_cnt_r + CNT_ONE;
      end
      if (bq_dec_s && !sii_niu_bqdq) begin
        bq_cnt_r <= bq_cnt_r - CNT_ONE;
      end else if (!bq_dec_s && sii_niu_bqdq && !bq_ovf_s) begin
        bq_cnt_r <= bq_cnt_r + CNT_ONE;
      end
    end
  end

  assign niu_sii_hdr_vld   = hdr_vld_r;
  assign niu_sii_reqbypass = reqbypass_r;
  assign niu_sii_datareq   = datareq_r;
  assign niu_sii_datareq16 = 1'b0;
  assign niu_sii_data      = data_r_out;
  assign niu_sii_parity    = parity_r;
  assign niu_sii_be        = be_r;
  assign credit_err        = credit_err_r;

endmodule

// File: tb/tb_niu_sii_dma_req_tx.sv
// Scoreboard bench for niu_sii_dma_req_tx: randomized requests and credit returns
// checked against a cycle-stamped expected-beat queue and a credit/occupancy model.
module tb_niu_sii_dma_req_tx;
  localparam int OQ = 16;
  localparam int BQ = 16;

  logic         iol2clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_vld = 1'b0, req_rdy, req_wr = 1'b0, req_bypass = 1'b0;
  logic [15:0]  req_tag = 16'd0;
  logic [39:0]  req_pa = 40'd0;
  logic [15:0]  req_be = 16'd0;
  logic [511:0] req_data = 512'd0;
  logic         sii_niu_oqdq = 1'b0, sii_niu_bqdq = 1'b0;
  logic         niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16;
  logic [127:0] niu_sii_data;
  logic [7:0]   niu_sii_parity;
  logic [15:0]  niu_sii_be;
  logic         credit_err;

  always #5 iol2clk = ~iol2clk;

  niu_sii_dma_req_tx #(.OQ_CREDITS(OQ), .BQ_CREDITS(BQ), .CW(5)) dut (
    .iol2clk(iol2clk), .reset(reset), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_wr(req_wr), .req_bypass(req_bypass), .req_tag(req_tag), .req_pa(req_pa),
    .req_be(req_be), .req_data(req_data), .sii_niu_oqdq(sii_niu_oqdq),
    .sii_niu_bqdq(sii_niu_bqdq), .niu_sii_hdr_vld(niu_sii_hdr_vld),
    .niu_sii_reqbypass(niu_sii_reqbypass), .niu_sii_datareq(niu_sii_datareq),
    .niu_sii_datareq16(niu_sii_datareq16), .niu_sii_data(niu_sii_data),
    .niu_sii_parity(niu_sii_parity), .niu_sii_be(niu_sii_be), .credit_err(credit_err)
  );

  typedef struct {
    int           due;
    bit           hdr;
    bit           byp;
    bit           dreq;
    logic [15:0]  be;
    logic [127:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    tests = 0, fails = 0;
  int    cyc = 0, free_at = 0;
  int    oq_m = OQ, bq_m = BQ;
  bit    err_m = 1'b0, rst_last = 1'b1;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_parity(input logic [127:0] d);
    logic [7:0] p;
    logic [15:0] lane;
    for (int i = 0; i < 8; i++) begin
      lane = d[16*i +: 16];
      p[i] = ($countones(lane) % 2) == 1;
    end
    return p;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One clock of stimulus plus the occupancy/credit model and scoreboard pushes
  task automatic step(input bit rst, input bit vld, input bit wr, input bit byp,
                      input logic [15:0] tag, input logic [39:0] pa, input logic [15:0] be,
                      input logic [511:0] d, input bit oq, input bit bq, output bit acc);
    bit exp_rdy;
    int doq, dbq;
    @(posedge iol2clk);
    #1;
    cyc++;
    reset = rst; req_vld = vld; req_wr = wr; req_bypass = byp; req_tag = tag;
    req_pa = pa; req_be = be; req_data = d; sii_niu_oqdq = oq; sii_niu_bqdq = bq;
    #2;
    acc = 1'b0;
    if (rst) begin
      chk("rdy_in_reset", {159'd0, req_rdy}, 160'd0);
      oq_m = OQ; bq_m = BQ; err_m = 1'b0; free_at = 0;
    end else begin
      if (rst_last) exp_q.delete();
      exp_rdy = (byp ? (bq_m > 0) : (oq_m > 0)) && (cyc >= free_at);
      chk("req_rdy", {159'd0, req_rdy}, {159'd0, exp_rdy});
      chk("credit_err", {159'd0, credit_err}, {159'd0, err_m});
      acc = vld && req_rdy;
      doq = 0; dbq = 0;
      if (acc) begin
        exp_q.push_back('{cyc + 1, 1'b1, byp, wr, be, {48'd0, tag, 24'd0, pa}});
        if (wr) begin
          for (int k = 0; k < 4; k++)
            exp_q.push_back('{cyc + 2 + k, 1'b0, 1'b0, 1'b0, 16'd0, d[128*k +: 128]});
        end
        free_at = cyc + (wr ? 5 : 1);
        if (byp) dbq = -1; else doq = -1;
      end
      if (oq) begin
        if (doq == -1) doq = 0;
        else if (oq_m == OQ) err_m = 1'b1;
        else doq = 1;
      end
      if (bq) begin
        if (dbq == -1) dbq = 0;
        else if (bq_m == BQ) err_m = 1'b1;
        else dbq = 1;
      end
      oq_m += doq; bq_m += dbq;
    end
    rst_last = rst;
  endtask

  task automatic rstep(input int pv, input int pw, input int pdq, output bit acc);
    step(1'b0, $urandom_range(99) < pv, $urandom_range(99) < pw, $urandom_range(1) == 1,
         16'($urandom), {8'($urandom), 32'($urandom)}, 16'($urandom), rnd512(),
         $urandom_range(99) < pdq, $urandom_range(99) < pdq, acc);
  endtask

  task automatic idle(input bit rst);
    bit a;
    step(rst, 1'b0, 1'b0, 1'b0, 16'd0, 40'd0, 16'd0, 512'd0, 1'b0, 1'b0, a);
  endtask

  // Monitor: every cycle the SII side must show exactly the beat due now, or idle
  initial begin
    bit rst_prev = 1'b0;
    beat_t e;
    logic [159:0] act;
    forever begin
      @(negedge iol2clk);
      act = {4'd0, niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16,
             niu_sii_be, niu_sii_data, niu_sii_parity};
      if (rst_prev) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
        chk("reset_outputs", act, 160'd0);
      end else begin
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          e = exp_q.pop_front();
          tests++; fails++;
          $display("FAIL missing_beat: beat due at cycle %0d not seen, now %0d", e.due, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          chk(e.hdr ? "sii_header" : "sii_payload", act,
              {4'd0, e.hdr, e.byp, e.dreq, 1'b0, e.be, e.data, ref_parity(e.data)});
        end else begin
          chk("sii_idle", act, 160'd0);
        end
      end
      rst_prev = reset;
    end
  end

  initial begin
    bit acc;
    bit got;
    logic [511:0] wdata;
    wdata = {{32{4'hD}}, {32{4'hC}}, {32{4'hB}}, {32{4'hA}}};
    repeat (3) idle(1'b1);
    idle(1'b0);
    // single bypass read, then a write with recognisable beats
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 40'h12_3456_7890, 16'h00FF, 512'd0, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'hBEEF, 40'hAB_CDEF_0123, 16'hFFFF, wdata, 1'b0, 1'b0, acc);
    repeat (6) idle(1'b0);
    // back-to-back: three reads then two writes with valid held high
    for (int r = 0; r < 5; r++) begin
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        step(1'b0, 1'b1, r >= 3, 1'b0, 16'(r), 40'(r * 64), 16'hFFFF, rnd512(), 1'b0, 1'b0, acc);
        got = acc;
      end
      chk("b2b_accept", {159'd0, got}, {159'd0, 1'b1});
    end
    repeat (6) idle(1'b0);
    // overflow: return at full ordered queue sets a sticky error
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 40'd0, 16'd0, 512'd0, 1'b1, 1'b0, acc);
    repeat (3) idle(1'b0);
    repeat (2) idle(1'b1);
    // heavy traffic with rare returns drains credits
    repeat (400) rstep(85, 30, 4, acc);
    // frequent returns exercise saturation
    repeat (300) rstep(60, 30, 45, acc);
    // reset in the middle of a write payload
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      step(1'b0, 1'b1, 1'b1, t[0], 16'hCAFE, 40'h1, 16'hFFFF, rnd512(), 1'b1, 1'b1, acc);
      got = acc;
    end
    chk("midwrite_accept", {159'd0, got}, {159'd0, 1'b1});
    repeat (2) idle(1'b0);
    idle(1'b1);
    repeat (200) rstep(70, 40, 10, acc);
    repeat (8) idle(1'b0);
    chk("queue_empty", 160'(exp_q.size()), 160'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
